// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl_pkg
//  Purpose  : Shared encodings for the byte-serial memory controller:
//             access-width codes, FSM state codes, request owner codes and
//             a helper that turns a width code into a byte count.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Access width codes as presented on mem_width
    localparam logic [1:0] c_mem_byte  = 2'b00;
    localparam logic [1:0] c_mem_half  = 2'b01;
    localparam logic [1:0] c_mem_word  = 2'b10;

    // Controller FSM states
    localparam logic [1:0] c_mem_idle  = 2'd0;
    localparam logic [1:0] c_mem_read  = 2'd1;
    localparam logic [1:0] c_mem_write = 2'd2;

    // Owner of the access currently in flight
    localparam logic       c_owner_if  = 1'b0;
    localparam logic       c_owner_mem = 1'b1;

    // Number of byte transfers for a width code; the reserved code 11
    // behaves as a full word.
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        logic [2:0] n;
        case (width)
            c_mem_byte: n = 3'd1;
            c_mem_half: n = 3'd2;
            default:    n = 3'd4;
        endcase
        return n;
    endfunction

endpackage : mem_ctrl_pkg
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_ctrl
//  Purpose  : Byte-serial memory controller arbitrating the IF and MEM
//             pipeline stages onto one 8-bit synchronous RAM port. Performs
//             1/2/4 little-endian byte transfers per request and returns a
//             one-cycle ready pulse with the assembled data.
//  Ports    :
//    clk, rst                     clock, synchronous active-high reset
//    if_req/if_addr/if_flush      IF fetch request, address, abort
//    if_rdy/if_data               IF completion pulse and fetched word
//    mem_req/mem_we/mem_width     MEM request, store flag, width code
//    mem_addr/mem_wdata           MEM address and store data
//    mem_rdy/mem_rdata            MEM completion pulse and load data
//    ram_addr/ram_wr/ram_dout     registered RAM address, strobe, byte
//    ram_din                      RAM read byte (one cycle after address)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch stage
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_rdy,
    output logic [31:0]       if_data,
    // memory stage
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_width,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_rdy,
    output logic [31:0]       mem_rdata,
    // RAM port
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    logic [1:0]        r_state;
    logic [2:0]        r_cnt;
    logic [2:0]        r_n;
    logic              r_owner;
    logic [ADDR_W-1:0] r_base;
    logic [31:0]       r_wdata;
    logic [31:0]       r_buf;

    logic              w_take_mem;
    logic              w_take_if;
    logic [2:0]        w_k;
    logic [ADDR_W-1:0] w_step_addr;
    logic [31:0]       w_buf_nxt;
    logic [7:0]        w_wbyte;

    // A port is only served while its own ready pulse is low, so a request
    // still held during its completion cycle is not taken a second time.
    assign w_take_mem  = mem_req & ~mem_rdy;
    assign w_take_if   = if_req & ~if_rdy & ~if_flush & ~w_take_mem;

    // r_cnt counts edges since the accepting edge; w_k is the index of the
    // edge now being taken (first edge after accept is k=1).
    assign w_k         = r_cnt + 3'd1;
    assign w_step_addr = r_base + ADDR_W'(w_k);

    // Byte k-2 arrives on ram_din at edge k, because the RAM registers the
    // address driven after edge k-1. The last byte is merged straight into
    // the completion value so data and ready leave on the same edge.
    always_comb begin
        w_buf_nxt = r_buf;
        w_wbyte   = r_wdata[7:0];
        for (int b = 0; b < 4; b++) begin
            if (w_k == 3'(b + 2)) begin
                w_buf_nxt[8*b +: 8] = ram_din;
            end
            if (w_k == 3'(b)) begin
                w_wbyte = r_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_mem_idle;
            r_cnt     <= 3'd0;
            r_n       <= 3'd0;
            r_owner   <= c_owner_if;
            r_base    <= '0;
            r_wdata   <= 32'd0;
            r_buf     <= 32'd0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_rdy    <= 1'b0;
            mem_rdy   <= 1'b0;
            if_data   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            if_rdy  <= 1'b0;
            mem_rdy <= 1'b0;
            case (r_state)
                c_mem_idle: begin
                    if (w_take_mem || w_take_if) begin
                        r_base   <= w_take_mem ? mem_addr : if_addr;
                        r_n      <= w_take_mem ? byte_count(mem_width) : 3'd4;
                        r_owner  <= w_take_mem ? c_owner_mem : c_owner_if;
                        r_wdata  <= mem_wdata;
                        r_buf    <= 32'd0;
                        r_cnt    <= 3'd0;
                        ram_addr <= w_take_mem ? mem_addr : if_addr;
                        if (w_take_mem && mem_we) begin
                            ram_wr   <= 1'b1;
                            ram_dout <= mem_wdata[7:0];
                            r_state  <= c_mem_write;
                        end else begin
                            ram_wr   <= 1'b0;
                            r_state  <= c_mem_read;
                        end
                    end
                end

                c_mem_read: begin
                    if (r_owner == c_owner_if && if_flush) begin
                        // Abandon the fetch; partially captured bytes are
                        // cleared on the next accept.
                        ram_wr  <= 1'b0;
                        r_state <= c_mem_idle;
                    end else begin
                        r_cnt <= w_k;
                        r_buf <= w_buf_nxt;
                        if (w_k < r_n) begin
                            ram_addr <= w_step_addr;
                        end
                        if (w_k == r_n + 3'd1) begin
                            if (r_owner == c_owner_if) begin
                                if_rdy  <= 1'b1;
                                if_data <= w_buf_nxt;
                            end else begin
                                mem_rdy   <= 1'b1;
                                mem_rdata <= w_buf_nxt;
                            end
                            r_state <= c_mem_idle;
                        end
                    end
                end

                c_mem_write: begin
                    r_cnt <= w_k;
                    if (w_k < r_n) begin
                        ram_addr <= w_step_addr;
                        ram_dout <= w_wbyte;
                    end else begin
                        ram_wr  <= 1'b0;
                        mem_rdy <= 1'b1;
                        r_state <= c_mem_idle;
                    end
                end

                default: begin
                    ram_wr  <= 1'b0;
                    r_state <= c_mem_idle;
                end
            endcase
        end
    end

endmodule : mem_ctrl
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_ctrl
//  Purpose  : Self-checking bench for mem_ctrl. A byte-addressed RAM model
//             answers the RAM port; a shadow memory predicts load data,
//             store bytes, address sequences and completion latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_flush, if_rdy;
    logic [31:0] if_addr, if_data;
    logic        mem_req, mem_we, mem_rdy;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] ram_addr;
    logic        ram_wr;
    logic [7:0]  ram_dout, ram_din;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdy(if_rdy), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_width(mem_width),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
        .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout),
        .ram_din(ram_din)
    );

    logic [7:0] ram    [logic [31:0]];
    logic [7:0] shadow [logic [31:0]];
    int n_checks = 0;
    int n_err    = 0;

    function automatic logic [7:0] dflt(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : dflt(a);
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    // Synchronous RAM: read data for the address seen at an edge appears
    // after that edge.
    always @(posedge clk) begin
        ram_din <= ram_rd(ram_addr);
        if (ram_wr) ram[ram_addr] = ram_dout;
    end

    task automatic preload(input logic [31:0] a, input logic [7:0] d);
        ram[a]    = d;
        shadow[a] = d;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: event not observed within cycle budget", name);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ram_addr"}, ram_addr, 32'd0);
        chk({tag, "_ram_wr"}, {31'd0, ram_wr}, 32'd0);
        chk({tag, "_ram_dout"}, {24'd0, ram_dout}, 32'd0);
        chk({tag, "_if_rdy"}, {31'd0, if_rdy}, 32'd0);
        chk({tag, "_mem_rdy"}, {31'd0, mem_rdy}, 32'd0);
        chk({tag, "_if_data"}, if_data, 32'd0);
        chk({tag, "_mem_rdata"}, mem_rdata, 32'd0);
    endtask

    // One complete access. Edge count includes the accepting edge, so a read
    // of n bytes completes on count n+2 and a store on count n+1.
    task automatic access(input bit is_if, input bit we, input logic [1:0] width,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] got);
        int          n, edges;
        bit          done;
        logic [31:0] exp;
        logic [31:0] addr_q[$];
        logic [39:0] wr_q[$];
        n   = is_if ? 4 : (width == 2'b00 ? 1 : (width == 2'b01 ? 2 : 4));
        exp = 32'd0;
        for (int i = 0; i < n; i++) exp |= 32'(sh_rd(addr + 32'(i))) << (8 * i);
        got = 32'd0;
        @(negedge clk);
        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            mem_req = 1'b1; mem_we = we; mem_width = width;
            mem_addr = addr; mem_wdata = wdata;
        end
        edges = 0;
        done  = 1'b0;
        while (!done && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (ram_wr) wr_q.push_back({ram_addr, ram_dout});
            else if (addr_q.size() == 0 || addr_q[addr_q.size()-1] != ram_addr)
                addr_q.push_back(ram_addr);
            if (is_if ? mem_rdy : if_rdy) flag_fail("other_port_rdy");
            if (is_if ? if_rdy : mem_rdy) begin
                done = 1'b1;
                got  = is_if ? if_data : mem_rdata;
            end
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if (!done) begin
            flag_fail("access_timeout");
            return;
        end
        chk("latency", 32'(edges), we ? 32'(n + 1) : 32'(n + 2));
        if (!we) begin
            chk("rdata", got, exp);
            chk("rd_no_wr", 32'(wr_q.size()), 32'd0);
            chk("rd_addr_cnt", 32'(addr_q.size()), 32'(n));
            for (int i = 0; i < n && i < addr_q.size(); i++)
                chk("rd_addr", addr_q[i], addr + 32'(i));
        end else begin
            chk("wr_cnt", 32'(wr_q.size()), 32'(n));
            for (int i = 0; i < n && i < wr_q.size(); i++) begin
                chk("wr_addr", wr_q[i][39:8], addr + 32'(i));
                chk("wr_byte", {24'd0, wr_q[i][7:0]}, {24'd0, wdata[8*i +: 8]});
            end
            for (int i = 0; i < n; i++) shadow[addr + 32'(i)] = wdata[8*i +: 8];
        end
        @(negedge clk);
        chk("rdy_one_cycle", {31'd0, is_if ? if_rdy : mem_rdy}, 32'd0);
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  width;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] got;
        int          e, mem_e, if_e;
        logic [31:0] mem_got, if_got;

        tbl[0] = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h0000_0513};
        tbl[1] = '{1'b0, 1'b0, 2'b01, 32'h0000_2001, 32'h0,         32'h0000_1234};
        tbl[2] = '{1'b0, 1'b1, 2'b00, 32'h0003_0000, 32'hAABB_CC41, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 2'b00, 32'h0003_0000, 32'h0,         32'h0000_0041};
        tbl[4] = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFFE, 32'hDEAD_BEEF, 32'h0};
        tbl[5] = '{1'b0, 1'b0, 2'b11, 32'hFFFF_FFFE, 32'h0,         32'hDEAD_BEEF};
        tbl[6] = '{1'b0, 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0,         32'h0000_ADBE};
        tbl[7] = '{1'b0, 1'b1, 2'b01, 32'h0000_0002, 32'h1234_5678, 32'h0};
        tbl[8] = '{1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0,         32'h5678_DEAD};
        tbl[9] = '{1'b0, 1'b0, 2'b00, 32'h0000_2002, 32'h0,         32'h0000_0012};

        rst = 1'b1;
        if_req = 1'b0; if_addr = 32'd0; if_flush = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_width = 2'b00;
        mem_addr = 32'd0; mem_wdata = 32'd0;
        preload(32'h100, 8'h13); preload(32'h101, 8'h05);
        preload(32'h102, 8'h00); preload(32'h103, 8'h00);
        preload(32'h2001, 8'h34); preload(32'h2002, 8'h12);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // directed vectors
        for (int i = 0; i < 10; i++) begin
            access(tbl[i].is_if, tbl[i].we, tbl[i].width, tbl[i].addr, tbl[i].wdata, got);
            if (!tbl[i].we) chk("tbl_data", got, tbl[i].exp);
        end

        // both stages request together: MEM first, IF right after mem_rdy
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h2001;
        if_req = 1'b1; if_addr = 32'h100;
        e = 0; mem_e = 0; if_e = 0; mem_got = 32'd0; if_got = 32'd0;
        while (if_e == 0 && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
            if (mem_rdy) begin
                if (mem_e == 0) mem_e = e;
                mem_got = mem_rdata; mem_req = 1'b0;
            end
            if (if_rdy) begin
                if_e = e; if_got = if_data; if_req = 1'b0;
            end
        end
        if_req = 1'b0; mem_req = 1'b0;
        if (if_e == 0) flag_fail("prio_timeout");
        chk("prio_mem_edge", 32'(mem_e), 32'd3);
        chk("prio_mem_data", mem_got, 32'h0000_0034);
        chk("prio_if_edge", 32'(if_e), 32'd9);
        chk("prio_if_data", if_got, 32'h0000_0513);
        @(negedge clk);

        // flush a fetch in its 2nd cycle, then a MEM load must start at once
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h100;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        if_flush = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("flush_ram_wr", {31'd0, ram_wr}, 32'd0);
        if (if_rdy) flag_fail("flush_if_rdy");
        if_flush = 1'b0; if_req = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_width = 2'b00; mem_addr = 32'h0003_0000;
        e = 0; mem_e = 0;
        while (mem_e == 0 && e < 20) begin
            @(posedge clk); e++; @(negedge clk);
            if (if_rdy) flag_fail("flush_if_rdy");
            if (mem_rdy) begin mem_e = e; mem_got = mem_rdata; end
        end
        mem_req = 1'b0;
        if (mem_e == 0) flag_fail("flush_mem_timeout");
        chk("flush_mem_edge", 32'(mem_e), 32'd3);
        chk("flush_mem_data", mem_got, 32'h0000_0041);
        @(negedge clk);

        // reset during the 3rd byte of a word store
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_width = 2'b10;
        mem_addr = 32'h0000_5000; mem_wdata = 32'h1122_3344;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rst_pre_wr", {31'd0, ram_wr}, 32'd1);
        chk("rst_pre_dout", {24'd0, ram_dout}, 32'h22);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        chk_reset_outputs("midrst");
        rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        repeat (6) begin
            @(posedge clk); @(negedge clk);
            if (mem_rdy) flag_fail("midrst_mem_rdy");
        end
        access(1'b1, 1'b0, 2'b10, 32'h100, 32'h0, got);

        // randomized traffic checked against the shadow memory
        for (int i = 0; i < 40; i++) begin
            bit          r_if, r_we;
            logic [1:0]  r_w;
            logic [31:0] r_a;
            r_if = ($urandom % 4) == 0;
            r_we = !r_if && ($urandom % 2);
            r_w  = 2'($urandom % 4);
            r_a  = (($urandom % 8) == 0) ? 32'hFFFF_FFFC + 32'($urandom % 4)
                                         : 32'h0000_4000 + 32'($urandom % 64);
            access(r_if, r_we, r_w, r_a, $urandom, got);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_mem_ctrl
`default_nettype wire
